// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
//   Shared definitions for initiators on the single-cycle data-memory port.
//   - dma_state_t : copy-engine control states
//   - DMEM_READ / DMEM_WRITE : dmemreq_type encodings
//   - word_align() : clears the byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    localparam logic DMEM_READ  = 1'b0;
    localparam logic DMEM_WRITE = 1'b1;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dmem_copy_engine_dpath.sv
// ---------------------------------------------------------------------------
// dmem_copy_engine_dpath
//   Datapath of the memory-copy engine: latched source/destination bases,
//   word count, word index, read-word buffer and the running 32-bit sum.
//   Request address/data are decoded from these registers only, so read
//   data never reaches an output combinationally.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset (clears sum only)
//   load          : accepted start; latches bases/count, clears index and sum
//   rd_cap        : READ cycle; captures rdata into buffer and adds to sum
//   wr_adv        : WRITE cycle; advances the word index
//   req_val       : registered request-valid from the control FSM
//   req_is_write  : registered request type from the control FSM
//   src_addr, dst_addr, count : start parameters
//   rdata         : memory read data
//   last_word     : current index is the final word of the transfer
//   sum           : running sum of words read
//   req_addr, req_wdata : request address / write data (0 when idle)
// ---------------------------------------------------------------------------
module dmem_copy_engine_dpath
    import dma_pkg::*;
#(
    parameter int p_cnt_nbits = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   rd_cap,
    input  logic                   wr_adv,
    input  logic                   req_val,
    input  logic                   req_is_write,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dst_addr,
    input  logic [p_cnt_nbits-1:0] count,
    input  logic [31:0]            rdata,
    output logic                   last_word,
    output logic [31:0]            sum,
    output logic [31:0]            req_addr,
    output logic [31:0]            req_wdata
);

    localparam int CW = p_cnt_nbits + 1;

    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [p_cnt_nbits-1:0] cnt_q, cnt_d;
    logic [p_cnt_nbits-1:0] idx_q, idx_d;
    logic [31:0]            buf_q, buf_d;
    logic [31:0]            sum_q, sum_d;

    logic [CW-1:0]          idx_inc;
    logic [31:0]            offset;

    // Extra bit so idx+1 never wraps before the compare against count.
    assign idx_inc   = {1'b0, idx_q} + CW'(1);
    assign last_word = (idx_inc == {1'b0, cnt_q});
    assign offset    = {{(30 - p_cnt_nbits){1'b0}}, idx_q, 2'b00};

    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        buf_d = buf_q;
        sum_d = sum_q;
        if (load) begin
            src_d = word_align(src_addr);
            dst_d = word_align(dst_addr);
            cnt_d = count;
            idx_d = '0;
            sum_d = '0;
        end else begin
            if (rd_cap) begin
                buf_d = rdata;
                sum_d = sum_q + rdata;
            end
            if (wr_adv) begin
                idx_d = idx_inc[p_cnt_nbits-1:0];
            end
        end
    end

    // Only sum is architecturally visible after reset; the other registers
    // are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
        src_q <= src_d;
        dst_q <= dst_d;
        cnt_q <= cnt_d;
        idx_q <= idx_d;
        buf_q <= buf_d;
    end

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        if (req_val) begin
            if (req_is_write == DMEM_WRITE) begin
                req_addr  = dst_q + offset;
                req_wdata = buf_q;
            end else begin
                req_addr  = src_q + offset;
            end
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/dmem_copy_engine.sv
// ---------------------------------------------------------------------------
// dmem_copy_engine
//   Memory-copy initiator on the single-cycle data-memory port. Copies
//   `count` words from src_addr to dst_addr, one read then one write per
//   word (2 cycles/word), and keeps a wrapping sum of every word read.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   go              : start request, sampled only in IDLE
//   src_addr        : source byte address ([1:0] ignored)
//   dst_addr        : destination byte address ([1:0] ignored)
//   count           : words to copy (0 goes straight to DONE)
//   busy            : transfer in progress, through the DONE cycle
//   done            : one-cycle completion pulse
//   sum             : sum of words read in the current/last transfer
//   dmemreq_val/type/addr/wdata : request to data memory
//   dmemresp_rdata  : same-cycle read response
// ---------------------------------------------------------------------------
module dmem_copy_engine
    import dma_pkg::*;
#(
    parameter int p_cnt_nbits = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dst_addr,
    input  logic [p_cnt_nbits-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            sum,
    output logic                   dmemreq_val,
    output logic                   dmemreq_type,
    output logic [31:0]            dmemreq_addr,
    output logic [31:0]            dmemreq_wdata,
    input  logic [31:0]            dmemresp_rdata
);

    dma_state_t state_q;
    logic       busy_q;
    logic       done_q;
    logic       val_q;
    logic       type_q;

    logic       load;
    logic       rd_cap;
    logic       wr_adv;
    logic       last_word;

    assign load   = (state_q == IDLE) && go;
    assign rd_cap = (state_q == READ);
    assign wr_adv = (state_q == WRITE);

    // Control FSM; request valid/type are registered together with the
    // next state so they always match the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            val_q   <= 1'b0;
            type_q  <= DMEM_READ;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        busy_q <= 1'b1;
                        if (count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            val_q   <= 1'b1;
                            type_q  <= DMEM_READ;
                        end
                    end
                end
                READ: begin
                    state_q <= WRITE;
                    type_q  <= DMEM_WRITE;
                end
                WRITE: begin
                    if (last_word) begin
                        state_q <= DONE;
                        val_q   <= 1'b0;
                        type_q  <= DMEM_READ;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= READ;
                        type_q  <= DMEM_READ;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    val_q   <= 1'b0;
                    type_q  <= DMEM_READ;
                end
            endcase
        end
    end

    dmem_copy_engine_dpath #(
        .p_cnt_nbits (p_cnt_nbits)
    ) u_dpath (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .rd_cap       (rd_cap),
        .wr_adv       (wr_adv),
        .req_val      (val_q),
        .req_is_write (type_q),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .count        (count),
        .rdata        (dmemresp_rdata),
        .last_word    (last_word),
        .sum          (sum),
        .req_addr     (dmemreq_addr),
        .req_wdata    (dmemreq_wdata)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign dmemreq_val  = val_q;
    assign dmemreq_type = type_q;

endmodule
